// File: rtl/mips_muldiv_if.sv
// Request/result bundle for the multiply/divide unit.
// master drives start/op/operands; slave returns hi/lo/busy/done/div_by_zero.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, rs_data, rt_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU (32 cycles + fix-up) and MTHI/MTLO; owns HI/LO.
// Ports: clk, rst_n (sync, active-low), bus (mips_muldiv_if.slave).
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_muldiv_if.slave  bus
);
  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, FIX
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   rs_q, rs_d;
  logic           mul_q, mul_d;
  logic           sgn_q, sgn_d;
  logic           rsgn_q, rsgn_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic           is_md, is_mthi, is_mtlo;
  logic           is_signed;
  logic [W-1:0]   a_abs, b_abs;
  logic [W:0]     acc;
  logic [W:0]     shl;
  logic [W:0]     diff;
  logic [2*W-1:0] res;

  assign is_md   = ~bus.op[2];
  assign is_mthi = bus.op == 3'b100;
  assign is_mtlo = bus.op == 3'b101;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    rs_d    = rs_q;
    mul_d   = mul_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    is_signed = ~bus.op[0];
    a_abs = (is_signed && bus.rs_data[W-1])
          ? -bus.rs_data : bus.rs_data;
    b_abs = (is_signed && bus.rt_data[W-1])
          ? -bus.rt_data : bus.rt_data;

    // multiply: add multiplicand into the upper half, carry kept
    acc = {1'b0, prod_q[2*W-1:W]}
        + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // divide: upper half is the remainder, lower half the
    // dividend shifting out / quotient shifting in
    shl  = prod_q[2*W-1:W-1];
    diff = shl - {1'b0, opnd_q};
    res  = sgn_q ? -prod_q : prod_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_md: begin
              prod_d  = {{W{1'b0}}, a_abs};
              opnd_d  = b_abs;
              rs_d    = bus.rs_data;
              mul_d   = ~bus.op[1];
              sgn_d   = is_signed &
                        (bus.rs_data[W-1] ^ bus.rt_data[W-1]);
              rsgn_d  = is_signed & bus.rs_data[W-1];
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = bus.op[1] ? DIV : MUL;
            end
            is_mthi: begin
              hi_d   = bus.rs_data;
              done_d = 1'b1;
            end
            is_mtlo: begin
              lo_d   = bus.rs_data;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        prod_d = {acc, prod_q[W-1:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      DIV: begin
        // diff[W] is the borrow: divisor did not fit
        prod_d = diff[W]
               ? {shl[W-1:0], prod_q[W-2:0], 1'b0}
               : {diff[W-1:0], prod_q[W-2:0], 1'b1};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (mul_q) begin
          {hi_d, lo_d} = res;
        end else if (opnd_q == '0) begin
          lo_d  = '1;
          hi_d  = rs_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = res[W-1:0];
          hi_d = rsgn_q ? -prod_q[2*W-1:W]
                        : prod_q[2*W-1:W];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      rs_q    <= '0;
      mul_q   <= 1'b0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      rs_q    <= rs_d;
      mul_q   <= mul_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv.
// Drives after posedge, samples on negedge.
module tb_mips_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_muldiv_if bus ();

  mips_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hold_hi = '0;
  logic [31:0] hold_lo = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb_, q, r;
    e.tag = "rand";
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    case (op)
      3'd0: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        {e.hi, e.lo} = p;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = p;
      end
      default: begin
        if (b == 0) begin
          e.lo  = 32'hFFFF_FFFF;
          e.hi  = a;
          e.dbz = 1'b1;
        end else if (op == 3'd2) begin
          sa   = longint'($signed(a));
          sb_  = longint'($signed(b));
          q    = sa / sb_;
          r    = sa % sb_;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // monitor: pops on done, otherwise HI/LO must hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_hi = '0;
      hold_lo = '0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
        chk({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
        chk({e.tag, "_dbz"}, 64'(bus.div_by_zero),
            64'(e.dbz));
        hold_hi = bus.hi;
        hold_lo = bus.lo;
      end
    end else begin
      chk("dbz_no_done", 64'(bus.div_by_zero), 64'd0);
      chk("hi_hold", 64'(bus.hi), 64'(hold_hi));
      chk("lo_hold", 64'(bus.lo), 64'(hold_lo));
    end
  end

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  task automatic wait_done(input string tag,
                           input int exp_lat);
    int n = 0;
    while (!bus.done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    if (exp_lat >= 0)
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b);
    exp_t e;
    e     = model(op, a, b);
    e.tag = tag;
    sb.push_back(e);
    issue(op, a, b);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(tag, 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;

    e = '{"mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    sb.push_back(e);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy", 64'(bus.busy), 64'd1);
    wait_done("mult", 33);

    // MULTU then DIVU issued in the done cycle
    e = '{"multu", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    sb.push_back(e);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 33);
    e = '{"b2b_divu", 32'd2, 32'd14, 1'b0};
    sb.push_back(e);
    issue(3'd3, 32'd100, 32'd7);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done("b2b_divu", 33);

    e = '{"div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    sb.push_back(e);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 33);

    e = '{"div_ovf", 32'h0, 32'h8000_0000, 1'b0};
    sb.push_back(e);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 33);

    e = '{"divu_zero", 32'h64, 32'hFFFF_FFFF, 1'b1};
    sb.push_back(e);
    issue(3'd3, 32'h64, 32'h0);
    wait_done("divu_zero", 33);

    run("div_zero_s", 3'd2, 32'hFFFF_FF00, 32'h0);
    run("div_rem_s", 3'd2, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'h0 : $urandom;
      if (i % 3 == 1) rb = rb >> 20;
      run("rand", rop, ra, rb);
    end

    // start while busy is ignored
    e = '{"mul_busy", 32'h0, 32'd12, 1'b0};
    sb.push_back(e);
    issue(3'd0, 32'd3, 32'd4);
    repeat (8) @(posedge clk);
    #1;
    issue(3'd2, 32'd100, 32'd5);
    chk("ign_busy", 64'(bus.busy), 64'd1);
    wait_done("mul_busy", 24);

    // reset mid-operation abandons it
    issue(3'd0, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mrst_hi", 64'(bus.hi), 64'd0);
    chk("mrst_lo", 64'(bus.lo), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_done", 64'(bus.done), 64'd0);

    e = '{"mtlo", 32'h0, 32'h1234, 1'b0};
    sb.push_back(e);
    issue(3'd5, 32'h1234, 32'h0);
    chk("mtlo_lo", 64'(bus.lo), 64'h1234);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    wait_done("mtlo", 0);

    e = '{"mthi", 32'hABCD_0001, 32'h1234, 1'b0};
    sb.push_back(e);
    issue(3'd4, 32'hABCD_0001, 32'h0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    wait_done("mthi", 0);

    issue(3'd6, 32'h5555_5555, 32'h1);
    chk("op6_busy", 64'(bus.busy), 64'd0);
    issue(3'd7, 32'h6666_6666, 32'h2);
    chk("op7_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It takes the two register read ports as operands and executes MULT, MULTU, DIV and DIVU over 32 iteration cycles. It also executes MTHI and MTLO in a single cycle, and holds the architectural HI/LO registers. Results are read out by MFHI/MFLO logic through the `hi`/`lo` outputs.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request strobe. Sampled on every rising edge; accepted only when `busy`=0.
- `op`  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are ignored.
- `rs_data`  in  32  operand A, connected to `read_data_1`.
- `rt_data`  in  32  operand B, connected to `read_data_2`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  an iterative operation is in progress.
- `done`  out  1  one-cycle pulse: `hi`/`lo` were just updated.
- `div_by_zero`  out  1  valid only while `done`=1: the completed DIV/DIVU had divisor 0.

## Operation
States: IDLE, MUL, DIV, FIX.

IDLE:
- `start`=1 with MULT/MULTU: latch operands into internal registers, clear the iteration counter, go to MUL.
- `start`=1 with DIV/DIVU: same latching, go to DIV.
- Signed ops latch the absolute values of the operands plus the result sign bits.
- MTHI: `hi` <= `rs_data` at the accepting edge; stay in IDLE.
- MTLO: `lo` <= `rs_data` at the accepting edge; stay in IDLE.
- Codes 110/111: no state change, no `done`.

MUL (32 cycles): shift-add on the 64-bit product register, one multiplier bit per cycle, LSB first.

DIV (32 cycles): restoring division, one quotient bit per cycle. Remainder width is 33 bits, so the subtract is never truncated.

Iteration counter: 6 bits. The last iteration (counter=31) moves the FSM to FIX.

FIX (1 cycle):
- Apply sign correction.
- Write `hi`/`lo`.
- Pulse `done` and return to IDLE.

Result rules:
- MULT/MULTU: {`hi`,`lo`} = 64-bit product. MULT is two's-complement.
- DIV/DIVU: `lo` = quotient, `hi` = remainder.
- Signed quotient truncates toward zero. Signed remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (signed): `lo`=0x80000000, `hi`=0.
- Divisor 0, DIV or DIVU: `lo`=0xFFFFFFFF, `hi`=`rs_data` as latched, and `div_by_zero`=1 with `done`.
  - Full latency still applies.
  - The signed fix-up is not applied.

Other rules:
- `start` while `busy`=1 is ignored. There is no queuing, and in-flight operands are not disturbed.
- `hi`/`lo` hold their old values throughout MUL/DIV. They change only in FIX or on an accepted MTHI/MTLO.
- `rs_data`/`rt_data` may change freely after the accepting edge.

## Timing
Reset (`rst_n`=0 at a rising edge) forces:
- state=IDLE
- `hi`=0, `lo`=0
- `busy`=0, `done`=0, `div_by_zero`=0

Reset wins over `start` in the same cycle. Reset mid-operation abandons the operation with no `done`.

Iterative operation, accepted at edge E:
- `busy`=1 from E through E+32.
- Edge E+33 (FIX) writes `hi`/`lo`. In the cycle after E+33, `busy`=0 and `done`=1.
- Latency: 33 edges from acceptance to new HI/LO.
- A new `start` in the `done` cycle is accepted (back-to-back ops).

MTHI/MTLO accepted at edge E:
- The register updates at E.
- `done`=1 in the following cycle.
- `busy` stays 0.

Outputs:
- All outputs are registered; there is no combinational path from inputs to outputs.
- `done` and `div_by_zero` are low in every cycle except the one-cycle `done` pulse.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles -> `hi`=0, `lo`=0, `busy`=0, `done`=0.
- MULT: `rs_data`=0xFFFFFFFD (-3), `rt_data`=5 -> after 33 edges, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, one-cycle `done`.
- MULTU: `rs_data`=0xFFFFFFFF, `rt_data`=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then immediate DIVU 100/7 in the `done` cycle -> `lo`=14, `hi`=2.
- DIV: `rs_data`=0xFFFFFFF9 (-7), `rt_data`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV overflow: `rs_data`=0x80000000, `rt_data`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU by zero: `rs_data`=0x64, `rt_data`=0 -> `lo`=0xFFFFFFFF, `hi`=0x64, `div_by_zero`=1 with `done`.
- Busy/reset/MT: start MULT 3*4.
  - Pulse `start` with DIV at cycle 10 -> ignored; result `lo`=12.
  - Start another MULT, drop `rst_n` at cycle 15 -> `hi`=`lo`=0, no `done`.
  - MTLO `rs_data`=0x1234 -> `lo`=0x1234 next cycle, `done`=1, `busy` never high.
